// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life engine: controller state
// encoding and the flat cell-index mapping used by every grid vector.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HALT  = 2'd3
  } life_state_t;

  // Cell (r,c) lives at bit r*cols+c of a flattened grid.
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_next_gen.sv
// Purely combinational B3/S23 next-generation calculator for a ROWS x COLS grid,
// with optional toroidal wrap of the neighbourhood.
module life_next_gen
  import life_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TOROIDAL = 0
) (
  input  logic [ROWS*COLS-1:0] grid,
  output logic [ROWS*COLS-1:0] next_grid
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] nb;
      logic [3:0] count;

      // Neighbour positions are resolved at elaboration, so every grid tap is a
      // constant index; position 4 is the cell itself and never contributes.
      for (genvar k = 0; k < 9; k++) begin : g_nb
        localparam int  RR_RAW   = r + k / 3 - 1;
        localparam int  CC_RAW   = c + k % 3 - 1;
        localparam int  RR       = (RR_RAW + ROWS) % ROWS;
        localparam int  CC       = (CC_RAW + COLS) % COLS;
        localparam bit  IN_RANGE = (RR_RAW >= 0) && (RR_RAW < ROWS) &&
                                   (CC_RAW >= 0) && (CC_RAW < COLS);
        if (k == 4) begin : g_self
          assign nb[k] = 1'b0;
        end else if (TOROIDAL != 0 || IN_RANGE) begin : g_tap
          assign nb[k] = grid[idx(RR, CC, COLS)];
        end else begin : g_edge
          assign nb[k] = 1'b0;
        end
      end

      assign count = 4'($countones(nb));
      assign next_grid[idx(r, c, COLS)] =
        (count == 4'd3) || (grid[idx(r, c, COLS)] && (count == 4'd2));
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life controller: grid register, run/pause/step/halt state machine,
// generation divider, saturating generation counter and stable/extinct flags.
module life_engine
  import life_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TOROIDAL = 0,
  parameter int STEP_DIV = 1,
  parameter int GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 step,
  input  logic [ROWS*COLS-1:0] seed,
  output logic [ROWS*COLS-1:0] display,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);

  localparam int CELLS = ROWS * COLS;
  localparam int DIV_W = $clog2(STEP_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  life_state_t      state_q, state_d;
  logic [CELLS-1:0] grid_q, grid_d, next_grid;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;
  logic             evolve;

  life_next_gen #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .TOROIDAL(TOROIDAL)
  ) u_next_gen (
    .grid     (grid_q),
    .next_grid(next_grid)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    div_d     = div_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;
    evolve    = 1'b0;

    if (clear) begin
      state_d   = IDLE;
      grid_d    = '0;
      gen_d     = '0;
      div_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end else if (load) begin
      state_d   = on ? RUN : PAUSE;
      grid_d    = seed;
      gen_d     = '0;
      div_d     = '0;
      stable_d  = 1'b0;
      extinct_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (on) begin
            state_d = RUN;
            grid_d  = seed;
            gen_d   = '0;
            div_d   = '0;
          end
        end
        RUN: begin
          // The terminal count evolves even when on drops in the same cycle.
          if (div_q == DIV_LAST) begin
            evolve = 1'b1;
            div_d  = '0;
          end else if (on) begin
            div_d = div_q + 1'b1;
          end
          if (!on) state_d = PAUSE;
        end
        PAUSE: begin
          evolve = step;
          if (on) state_d = RUN;
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end

    // A halting evolution overrides whatever transition the state logic chose.
    if (evolve) begin
      grid_d = next_grid;
      if (gen_q != '1) gen_d = gen_q + 1'b1;
      if (next_grid == '0) begin
        extinct_d = 1'b1;
        stable_d  = 1'b0;
        state_d   = HALT;
      end else if (next_grid == grid_q) begin
        stable_d  = 1'b1;
        extinct_d = 1'b0;
        state_d   = HALT;
      end else begin
        stable_d  = 1'b0;
        extinct_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      div_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      div_q     <= div_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
    end
  end

  assign display   = grid_q;
  assign gen_count = gen_q;
  assign running   = (state_q == RUN);
  assign stable    = stable_q;
  assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: three 8x8 instances (plain with 3-bit counter,
// toroidal, STEP_DIV=4) share stimulus and are tracked by a behavioural model.
module tb_life_engine;

  logic        clk = 1'b0;
  logic        reset, on, load, clear, step;
  logic [63:0] seed;

  logic [63:0] disp0, disp1, disp2;
  logic [2:0]  gen0;
  logic [15:0] gen1, gen2;
  logic        run0, run1, run2, st0, st1, st2, ex0, ex1, ex2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  life_engine #(.ROWS(8), .COLS(8), .TOROIDAL(0), .STEP_DIV(1), .GEN_W(3)) dut (
    .clk(clk), .reset(reset), .on(on), .load(load), .clear(clear), .step(step),
    .seed(seed), .display(disp0), .gen_count(gen0), .running(run0),
    .stable(st0), .extinct(ex0));

  life_engine #(.ROWS(8), .COLS(8), .TOROIDAL(1), .STEP_DIV(1), .GEN_W(16)) dut_t (
    .clk(clk), .reset(reset), .on(on), .load(load), .clear(clear), .step(step),
    .seed(seed), .display(disp1), .gen_count(gen1), .running(run1),
    .stable(st1), .extinct(ex1));

  life_engine #(.ROWS(8), .COLS(8), .TOROIDAL(0), .STEP_DIV(4), .GEN_W(16)) dut_d (
    .clk(clk), .reset(reset), .on(on), .load(load), .clear(clear), .step(step),
    .seed(seed), .display(disp2), .gen_count(gen2), .running(run2),
    .stable(st2), .extinct(ex2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cells(input int a, input int b, input int c, input int d);
    logic [63:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    return m;
  endfunction

  // Behavioural model: grid as a 2-D picture, rules applied cell by cell.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_HALT} mode_t;
  int          sd  [3] = '{1, 1, 4};
  bit          tor [3] = '{1'b0, 1'b1, 1'b0};
  int          gw  [3] = '{3, 16, 16};
  mode_t       m_mode [3];
  logic [63:0] m_grid [3];
  int          m_gen  [3];
  int          m_div  [3];
  bit          m_st   [3];
  bit          m_ex   [3];
  bit          model_valid = 1'b0;

  function automatic logic [63:0] life_next(input logic [63:0] g, input bit wrap);
    logic [63:0] res;
    bit pic [8][8];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        pic[r][c] = g[r*8+c];
    res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
              n += int'(pic[rr][cc]);
          end
        end
        res[r*8+c] = (n == 3) || (pic[r][c] && n == 2);
      end
    end
    return res;
  endfunction

  task automatic model_update(input int k);
    logic [63:0] nx;
    bit ev;
    ev = 1'b0;
    if (reset) begin
      m_mode[k] = M_IDLE; m_grid[k] = '0; m_gen[k] = 0; m_div[k] = 0;
      m_st[k] = 1'b0; m_ex[k] = 1'b0;
    end else if (clear) begin
      m_mode[k] = M_IDLE; m_grid[k] = '0; m_gen[k] = 0; m_div[k] = 0;
      m_st[k] = 1'b0; m_ex[k] = 1'b0;
    end else if (load) begin
      m_mode[k] = on ? M_RUN : M_PAUSE; m_grid[k] = seed; m_gen[k] = 0; m_div[k] = 0;
      m_st[k] = 1'b0; m_ex[k] = 1'b0;
    end else begin
      case (m_mode[k])
        M_IDLE: if (on) begin
          m_mode[k] = M_RUN; m_grid[k] = seed; m_gen[k] = 0; m_div[k] = 0;
        end
        M_RUN: begin
          if (m_div[k] == sd[k] - 1) begin
            ev = 1'b1;
            m_div[k] = 0;
          end else if (on) begin
            m_div[k] = m_div[k] + 1;
          end
          if (!on) m_mode[k] = M_PAUSE;
        end
        M_PAUSE: begin
          ev = step;
          if (on) m_mode[k] = M_RUN;
        end
        default: ;
      endcase
      if (ev) begin
        nx = life_next(m_grid[k], tor[k]);
        if (m_gen[k] < (1 << gw[k]) - 1) m_gen[k] = m_gen[k] + 1;
        m_ex[k] = (nx == '0);
        m_st[k] = (nx != '0) && (nx == m_grid[k]);
        if (m_ex[k] || m_st[k]) m_mode[k] = M_HALT;
        m_grid[k] = nx;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_update(k);
    if (reset) model_valid = 1'b1;
  end

  task automatic cmp_inst(input int k, input logic [63:0] d, input logic [15:0] g,
                          input logic r, input logic s, input logic e);
    check($sformatf("m%0d.display", k), d, m_grid[k]);
    check($sformatf("m%0d.gen_count", k), 64'(g), 64'(m_gen[k]));
    check($sformatf("m%0d.running", k), 64'(r), 64'(m_mode[k] == M_RUN));
    check($sformatf("m%0d.stable", k), 64'(s), 64'(m_st[k]));
    check($sformatf("m%0d.extinct", k), 64'(e), 64'(m_ex[k]));
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      cmp_inst(0, disp0, 16'(gen0), run0, st0, ex0);
      cmp_inst(1, disp1, gen1, run1, st1, ex1);
      cmp_inst(2, disp2, gen2, run2, st2, ex2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [63:0] blink_h, blink_v, block, wrap_v, wrap_h;

  initial begin
    blink_h = cells(26, 27, 28, -1);
    blink_v = cells(19, 27, 35, -1);
    block   = cells(0, 1, 8, 9);
    wrap_v  = cells(56, 0, 8, -1);
    wrap_h  = cells(7, 0, 1, -1);

    reset = 1'b1; on = 1'b0; load = 1'b0; clear = 1'b0; step = 1'b0; seed = '0;
    tick(2);
    check("reset display", disp0, 64'h0);
    check("reset gen", 64'(gen0), 64'h0);
    check("reset flags", {61'b0, run0, st0, ex0}, 64'h0);
    reset = 1'b0;

    // step in IDLE is ignored
    step = 1'b1; seed = blink_h;
    tick(1);
    check("idle step ignored", disp0, 64'h0);
    step = 1'b0;

    // blinker, one generation per cycle, 3-bit counter saturates
    load = 1'b1; on = 1'b1;
    tick(1);
    load = 1'b0;
    check("blink load", disp0, blink_h);
    check("blink gen0", 64'(gen0), 64'd0);
    check("blink running", 64'(run0), 64'd1);
    tick(1);
    check("blink gen1 disp", disp0, blink_v);
    check("blink gen1 cnt", 64'(gen0), 64'd1);
    tick(1);
    check("blink gen2 disp", disp0, blink_h);
    tick(10);
    check("blink sat disp", disp0, blink_h);
    check("blink sat cnt", 64'(gen0), 64'd7);

    // still life halts as stable and ignores on/step
    seed = block; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("block load", disp0, block);
    tick(1);
    check("block stable", 64'(st0), 64'd1);
    check("block gen", 64'(gen0), 64'd1);
    check("block halted", 64'(run0), 64'd0);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    check("block frozen", disp0, block);
    check("block frozen gen", 64'(gen0), 64'd1);

    // single cell dies
    seed = cells(27, -1, -1, -1); load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(1);
    check("extinct disp", disp0, 64'h0);
    check("extinct flags", {62'b0, st0, ex0}, 64'h1);
    check("extinct gen", 64'(gen0), 64'd1);
    check("extinct halted", 64'(run0), 64'd0);

    // toroidal wrap blinker across the corner
    seed = wrap_v; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("wrap load", disp1, wrap_v);
    tick(1);
    check("wrap gen1", disp1, wrap_h);
    tick(1);
    check("wrap gen2", disp1, wrap_v);

    // pause and step on the divided instance
    seed = blink_h; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    on = 1'b0;
    tick(1);
    check("pause disp", disp2, blink_h);
    check("pause running", 64'(run2), 64'd0);
    tick(3);
    check("pause frozen", disp2, blink_h);
    check("pause gen", 64'(gen2), 64'd0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    check("step disp", disp2, blink_v);
    check("step gen", 64'(gen2), 64'd1);
    tick(2);
    check("step once only", disp2, blink_v);
    on = 1'b1;
    tick(1);
    check("resume running", 64'(run2), 64'd1);
    tick(1);
    check("resume div held", disp2, blink_v);
    tick(1);
    check("resume evolve", disp2, blink_h);
    check("resume gen", 64'(gen2), 64'd2);

    // clear beats load, then IDLE picks up seed when on
    load = 1'b1; clear = 1'b1;
    tick(1);
    load = 1'b0; clear = 1'b0; on = 1'b0;
    check("clear wins disp", disp2, 64'h0);
    check("clear idle", 64'(run2), 64'd0);
    on = 1'b1;
    tick(1);
    check("idle start disp", disp2, blink_h);
    check("idle start run", 64'(run2), 64'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("reset mid-run disp", disp0 | disp1 | disp2, 64'h0);
    check("reset mid-run outs", {run0, run2, st2, ex2, 16'(gen0) | gen2}, 20'h0);
    reset = 1'b0; on = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Conway's Game of Life controller: holds a ROWS×COLS cell grid in a register, loads a seed, and evolves the grid by B3/S23 rules at a programmable rate. It supports run, pause, single-step and clear modes, plus optional toroidal wrap, a generation counter and stable/extinct detection. It sits between the user/testbench control inputs and the LED/display driver, replacing the fixed 8×8 free-running controller.

## Interface

- ROWS, default 8: grid rows (≥3).
- COLS, default 8: grid columns (≥3).
- TOROIDAL, default 0: 1 means edges wrap; 0 means off-grid neighbours are dead.
- STEP_DIV, default 1: clock cycles per generation while running (≥1).
- GEN_W, default 16: generation counter width.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- on  in  1  run enable (level).
- load  in  1  seed load strobe (single-cycle pulse).
- clear  in  1  synchronous clear strobe.
- step  in  1  single-step strobe; honoured only in PAUSE.
- seed  in  ROWS*COLS  initial grid; cell (r,c) at bit r*COLS+c.
- display  out  ROWS*COLS  current grid, driven directly from the grid register.
- gen_count  out  GEN_W  generations since the last load; saturates at all-ones.
- running  out  1  high when state is RUN.
- stable  out  1  last evolution produced an identical, non-empty grid.
- extinct  out  1  last evolution produced an all-zero grid.

## Operation

- States are IDLE, RUN, PAUSE and HALT.
- Reset: state=IDLE, grid=0, gen_count=0, stable=0, extinct=0, divider=0. All outputs read 0.
- Priority each cycle: reset > clear > load > state logic.
- clear (any state): grid=0, gen_count=0, flags=0, divider=0, next state IDLE.
- load (any state): grid=seed, gen_count=0, flags=0, divider=0. Next state is RUN if on, else PAUSE.
- IDLE: if on, grid=seed, gen_count=0, go to RUN. step is ignored.
- RUN: the divider counts 0..STEP_DIV-1. At the terminal count, evolve and reset the divider to 0. If on=0, go to PAUSE; the divider holds and the grid is frozen. If on=0 coincides with the terminal count, the evolution still happens this cycle.
- PAUSE: a step pulse evolves exactly once. If on, go to RUN and resume the divider from its held value. step and on together: evolve once, then go to RUN.
- Evolve: grid=next(grid) and gen_count++ (saturating).
  - If next==0: extinct=1 and go to HALT.
  - Else if next==grid: stable=1 and go to HALT.
  - Otherwise both flags are cleared.
- HALT: grid, gen_count and flags are frozen. on and step are ignored. Leave HALT only by load, clear or reset.
- Neighbour count: 8 neighbours, summed at 4-bit width.
  - TOROIDAL=1: row and column indices wrap modulo ROWS and COLS.
  - TOROIDAL=0: out-of-range neighbours count as 0.
- Rule: a live cell survives with 2 or 3 neighbours; a dead cell is born with exactly 3.

## Timing

- Every input is sampled at posedge; effects are visible on outputs the following cycle. There are no combinational input-to-output paths.
- Load latency: 1 cycle to display=seed.
- First evolution occurs STEP_DIV cycles after RUN is entered. STEP_DIV=1 means one generation per cycle.
- Step latency in PAUSE: the new generation appears 1 cycle after the step pulse.
- A strobe held high for N cycles acts N times. step held high in PAUSE therefore advances one generation per cycle until HALT.
- The divider width is $clog2(STEP_DIV+1).

## Structure

- life_pkg holds the state enum type (IDLE, RUN, PAUSE, HALT) and a cell-index function idx(r,c)=r*COLS+c.
- Sub-module life_next_gen #(ROWS, COLS, TOROIDAL) is purely combinational: grid in, next grid out. It is instantiated once.
- The top level contains the state machine, grid register, divider, generation counter and flag logic.

## Test plan

- **Blinker.** 8×8, STEP_DIV=1, seed bits {26,27,28}, load with on=1. Display must alternate {19,27,35} and {26,27,28} every cycle; gen_count increments by 1 per cycle; stable=extinct=0.
- **Still life.** Seed block {0,1,8,9}, run. After one generation: stable=1, state HALT, gen_count=1, display unchanged, and it stays frozen with on=1.
- **Extinction.** Seed a single cell, bit 27, run. After one generation: display=0, extinct=1, stable=0, HALT, gen_count=1.
- **Wrap.** TOROIDAL=1, seed {56,0,8}, run. Display must become {7,0,1}, then return to {56,0,8}.
- **Pause and step.** STEP_DIV=4, run a blinker, drop on mid-count. Display must be frozen. One step pulse gives exactly one generation on the next cycle, with gen_count+1. Raising on resumes from the held divider value.
- **Priority and reset.** In RUN, assert load and clear together: display=0 and IDLE. Then assert reset mid-RUN: all outputs 0 on the next cycle.
